// File: rtl/memory_access_unit_if.sv
// Pipeline M-stage and data-bus signals of the memory access unit.
// The slave modport is the unit itself; the master modport is its environment.
interface memory_access_unit_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
);
    // Pipeline side
    logic              in_valid;
    logic              in_load;
    logic              in_store;
    logic [ADDR_W-1:0] in_addr;
    logic [2:0]        in_size;
    logic              in_unsigned;
    logic [XLEN-1:0]   in_wdata;
    logic              advance;
    logic              flush;
    // Bus request
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [XLEN/8-1:0] dreq_strobe;
    logic [XLEN-1:0]   dreq_data;
    // Bus response
    logic              dresp_data_ok;
    logic [XLEN-1:0]   dresp_data;
    // Results
    logic [XLEN-1:0]   rdata;
    logic              misalign;
    logic              skip;
    logic              stall;

    modport master (
        output in_valid, in_load, in_store, in_addr, in_size, in_unsigned, in_wdata,
        output advance, flush, dresp_data_ok, dresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  rdata, misalign, skip, stall
    );

    modport slave (
        input  in_valid, in_load, in_store, in_addr, in_size, in_unsigned, in_wdata,
        input  advance, flush, dresp_data_ok, dresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output rdata, misalign, skip, stall
    );
endinterface

// File: rtl/memory_access_unit.sv
// M-stage memory access unit: issues load/store requests on the data bus,
// aligns store data, extends load data, and tracks an outstanding request
// across pipeline stalls and flushes.
module memory_access_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input logic                 clk,
    input logic                 reset,
    memory_access_unit_if.slave bus_io
);
    localparam int unsigned SW = XLEN / 8;
    localparam int unsigned OW = $clog2(SW);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [SW-1:0]     strobe_q, strobe_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              load_q, load_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   cap_q, cap_d;

    logic              acc;
    logic              mis;
    logic              req_valid;
    logic [OW-1:0]     off;
    logic [XLEN-1:0]   idle_rdata;
    logic [XLEN-1:0]   wait_rdata;

    // Shift the addressed bytes down and sign/zero-extend them to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [OW-1:0]   o,
                                               input logic [2:0]      size,
                                               input logic            uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        int              nbits;
        sh  = raw >> {o, 3'b000};
        res = '0;
        if (32'(size) > 32'(OW)) nbits = int'(XLEN);
        else                     nbits = 8 << size;
        for (int i = 0; i < int'(XLEN); i++) begin
            res[i] = (i < nbits) ? sh[i] : (uns ? 1'b0 : sh[nbits-1]);
        end
        return res;
    endfunction

    // Byte-enable mask for a store of 2^size bytes at byte offset o.
    function automatic logic [SW-1:0] strobe_of(input logic [OW-1:0] o,
                                                input logic [2:0]  size);
        logic [15:0] m;
        case (size)
            3'd0:    m = 16'h0001;
            3'd1:    m = 16'h0003;
            3'd2:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << o;
        return m[SW-1:0];
    endfunction

    // Access decode, alignment check and MMIO detection.
    always_comb begin
        off = bus_io.in_addr[OW-1:0];
        acc = bus_io.in_valid & (bus_io.in_load | bus_io.in_store) & ~bus_io.flush;
        mis = acc & (((bus_io.in_addr & ((ADDR_W'(1) << bus_io.in_size) - ADDR_W'(1))) != '0)
                     || (32'(bus_io.in_size) > 32'(OW)));
        bus_io.misalign = mis & ~reset;
        bus_io.skip     = acc & ~bus_io.in_addr[31] & ~reset;
        idle_rdata = bus_io.in_load ?
                     extend(bus_io.dresp_data, off, bus_io.in_size, bus_io.in_unsigned) : '0;
        wait_rdata = load_q ? extend(bus_io.dresp_data, addr_q[OW-1:0], size_q, uns_q) : '0;
    end

    // Next-state, request register updates and bus/pipeline outputs.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        data_d   = data_q;
        load_d   = load_q;
        uns_d    = uns_q;
        cap_d    = cap_q;
        req_valid          = 1'b0;
        bus_io.dreq_addr   = addr_q;
        bus_io.dreq_size   = size_q;
        bus_io.dreq_strobe = strobe_q;
        bus_io.dreq_data   = data_q;
        bus_io.rdata       = '0;
        bus_io.stall       = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_valid          = acc & ~mis;
                bus_io.dreq_addr   = bus_io.in_addr;
                bus_io.dreq_size   = bus_io.in_size;
                bus_io.dreq_strobe = bus_io.in_store ? strobe_of(off, bus_io.in_size) : '0;
                bus_io.dreq_data   = bus_io.in_wdata << {off, 3'b000};
                bus_io.rdata       = idle_rdata;
                bus_io.stall       = req_valid & ~bus_io.dresp_data_ok;
                if (req_valid && bus_io.dresp_data_ok) begin
                    cap_d   = idle_rdata;
                    state_d = bus_io.advance ? StIdle : StDone;
                end else if (req_valid) begin
                    addr_d   = bus_io.dreq_addr;
                    size_d   = bus_io.dreq_size;
                    strobe_d = bus_io.dreq_strobe;
                    data_d   = bus_io.dreq_data;
                    load_d   = bus_io.in_load;
                    uns_d    = bus_io.in_unsigned;
                    state_d  = StWait;
                end
            end
            StWait: begin
                req_valid    = 1'b1;
                bus_io.rdata = wait_rdata;
                bus_io.stall = ~bus_io.dresp_data_ok;
                if (bus_io.dresp_data_ok) begin
                    if (bus_io.flush) begin
                        state_d = StIdle;
                    end else begin
                        cap_d   = wait_rdata;
                        state_d = bus_io.advance ? StIdle : StDone;
                    end
                end else if (bus_io.flush) begin
                    state_d = StDrain;
                end
            end
            StDone: begin
                bus_io.rdata = cap_q;
                if (bus_io.advance || bus_io.flush) state_d = StIdle;
            end
            StDrain: begin
                // Old request is dead; a new access waits for IDLE.
                req_valid    = 1'b1;
                bus_io.stall = acc;
                if (bus_io.dresp_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (reset) begin
            req_valid    = 1'b0;
            bus_io.stall = 1'b0;
        end
        bus_io.dreq_valid = req_valid;
    end

    // State and request/capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            uns_q    <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            load_q   <= load_d;
            uns_q    <= uns_d;
            cap_q    <= cap_d;
        end
    end
endmodule
